lb_window_gen: RTL and testbench

//  Downstream consumer of the memory-core line buffer. Pairs each live pixel (the stream

---
 rtl/lb_window_gen.sv | 158 +++++++++++++++
 tb/tb_lb_window_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lb_window_gen.sv
// 2-row x 3-column stencil window generator pairing the live pixel stream with the
// one-line-delayed stream from the line buffer; registered window output with valid strobe.
module lb_window_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 64
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic                  config_en,
  input  logic [31:0]           config_addr,
  input  logic [31:0]           config_data,
  output logic [31:0]           read_data,
  input  logic [DATA_WIDTH-1:0] cur_in,
  input  logic                  cur_valid,
  input  logic [DATA_WIDTH-1:0] lb_in,
  input  logic                  lb_valid,
  output logic [DATA_WIDTH-1:0] win_top0,
  output logic [DATA_WIDTH-1:0] win_top1,
  output logic [DATA_WIDTH-1:0] win_top2,
  output logic [DATA_WIDTH-1:0] win_bot0,
  output logic [DATA_WIDTH-1:0] win_bot1,
  output logic [DATA_WIDTH-1:0] win_bot2,
  output logic                  win_valid,
  output logic [15:0]           win_col,
  output logic                  err_sticky
);

  localparam logic [15:0] MAX_W = 16'(IMG_WIDTH);
  localparam logic [15:0] MIN_W = 16'd3;

  logic [15:0]           line_width_q, line_width_d;
  logic [15:0]           col_cnt_q, col_cnt_d;
  logic                  primed_q, primed_d;
  logic                  win_valid_q, win_valid_d;
  logic                  err_q, err_d;
  logic [15:0]           win_col_q, win_col_d;
  logic [DATA_WIDTH-1:0] top_q [3];
  logic [DATA_WIDTH-1:0] top_d [3];
  logic [DATA_WIDTH-1:0] bot_q [3];
  logic [DATA_WIDTH-1:0] bot_d [3];
  logic [DATA_WIDTH-1:0] wtop_q [3];
  logic [DATA_WIDTH-1:0] wtop_d [3];
  logic [DATA_WIDTH-1:0] wbot_q [3];
  logic [DATA_WIDTH-1:0] wbot_d [3];

  logic        cfg_wr;
  logic        clr;
  logic        accept;
  logic        primed_now;
  logic        at_line_end;
  logic        emit;
  logic [15:0] cfg_width;

  always_comb begin
    cfg_wr      = clk_en & config_en & (config_addr[7:0] == 8'd0);
    clr         = clk_en & (flush | cfg_wr);
    accept      = clk_en & cur_valid & ~flush & ~cfg_wr;
    primed_now  = primed_q | lb_valid;
    at_line_end = (col_cnt_q >= (line_width_q - 16'd1));
    emit        = accept & primed_now & (col_cnt_q >= 16'd2);
    if (config_data[15:0] < MIN_W) begin
      cfg_width = MIN_W;
    end else if (config_data[15:0] > MAX_W) begin
      cfg_width = MAX_W;
    end else begin
      cfg_width = config_data[15:0];
    end
  end

  always_comb begin
    line_width_d = line_width_q;
    col_cnt_d    = col_cnt_q;
    primed_d     = primed_q;
    win_valid_d  = win_valid_q;
    err_d        = err_q;
    win_col_d    = win_col_q;
    top_d        = top_q;
    bot_d        = bot_q;
    wtop_d       = wtop_q;
    wbot_d       = wbot_q;

    if (clk_en) begin
      win_valid_d = 1'b0;
      if (cfg_wr) begin
        line_width_d = cfg_width;
      end
      if (clr) begin
        col_cnt_d = '0;
        primed_d  = 1'b0;
        err_d     = 1'b0;
        top_d     = '{default: '0};
        bot_d     = '{default: '0};
      end else begin
        if (accept) begin
          top_d[0]  = top_q[1];
          top_d[1]  = top_q[2];
          top_d[2]  = lb_valid ? lb_in : '0;
          bot_d[0]  = bot_q[1];
          bot_d[1]  = bot_q[2];
          bot_d[2]  = cur_in;
          col_cnt_d = at_line_end ? '0 : col_cnt_q + 16'd1;
          primed_d  = primed_now;
        end
        // Output window registers load only on emit so data holds between strobes.
        if (emit) begin
          win_valid_d = 1'b1;
          win_col_d   = col_cnt_q;
          wtop_d      = top_d;
          wbot_d      = bot_d;
        end
        if ((lb_valid & ~cur_valid) | (accept & ~lb_valid & primed_q)) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      line_width_q <= MAX_W;
      col_cnt_q    <= '0;
      primed_q     <= 1'b0;
      win_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      win_col_q    <= '0;
      top_q        <= '{default: '0};
      bot_q        <= '{default: '0};
      wtop_q       <= '{default: '0};
      wbot_q       <= '{default: '0};
    end else begin
      line_width_q <= line_width_d;
      col_cnt_q    <= col_cnt_d;
      primed_q     <= primed_d;
      win_valid_q  <= win_valid_d;
      err_q        <= err_d;
      win_col_q    <= win_col_d;
      top_q        <= top_d;
      bot_q        <= bot_d;
      wtop_q       <= wtop_d;
      wbot_q       <= wbot_d;
    end
  end

  // Masking by clk_en keeps a held window from being seen twice across a freeze.
  assign win_valid  = win_valid_q & clk_en;
  assign read_data  = {16'b0, line_width_q};
  assign win_top0   = wtop_q[0];
  assign win_top1   = wtop_q[1];
  assign win_top2   = wtop_q[2];
  assign win_bot0   = wbot_q[0];
  assign win_bot1   = wbot_q[1];
  assign win_bot2   = wbot_q[2];
  assign win_col    = win_col_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_lb_window_gen.sv
// Bench for lb_window_gen: config table vectors plus stream scenarios checked
// against a queue of expected windows derived from the stimulus formula.
module tb_lb_window_gen;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic        clk_en, flush, config_en, cur_valid, lb_valid;
  logic [31:0] config_addr, config_data, read_data;
  logic [15:0] cur_in, lb_in;
  logic [15:0] win_top0, win_top1, win_top2, win_bot0, win_bot1, win_bot2, win_col;
  logic        win_valid, err_sticky;

  int tests = 0;
  int fails = 0;
  int n_win = 0;
  logic [31:0] ecyc = '0;

  typedef struct packed {
    logic [111:0] win;
    logic [31:0]  tag;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        en;
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] exp;
  } cfg_vec_t;
  cfg_vec_t tbl[10];

  lb_window_gen #(.DATA_WIDTH(16), .IMG_WIDTH(64)) dut (
    .clk_in(clk_in), .reset(reset_n), .clk_en(clk_en), .flush(flush),
    .config_en(config_en), .config_addr(config_addr), .config_data(config_data),
    .read_data(read_data), .cur_in(cur_in), .cur_valid(cur_valid), .lb_in(lb_in),
    .lb_valid(lb_valid), .win_top0(win_top0), .win_top1(win_top1), .win_top2(win_top2),
    .win_bot0(win_bot0), .win_bot1(win_bot1), .win_bot2(win_bot2),
    .win_valid(win_valid), .win_col(win_col), .err_sticky(err_sticky)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) if (reset_n && clk_en) ecyc <= ecyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (reset_n === 1'b1 && win_valid === 1'b1) begin
      exp_t e;
      n_win++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_window: got col %0d, expected no window", win_col);
      end else begin
        e = sb.pop_front();
        if ({win_top0, win_top1, win_top2, win_bot0, win_bot1, win_bot2, win_col} !== e.win
            || ecyc !== e.tag) begin
          fails++;
          $display("FAIL window: got %h @%0d, expected %h @%0d",
                   {win_top0, win_top1, win_top2, win_bot0, win_bot1, win_bot2, win_col},
                   ecyc, e.win, e.tag);
        end
      end
    end
  end

  task automatic drive(input logic en, input logic fl, input logic cv, input logic [15:0] cur,
                       input logic lv, input logic [15:0] lb, input logic cfg,
                       input logic [31:0] ca, input logic [31:0] cd);
    clk_en = en; flush = fl; cur_valid = cv; cur_in = cur; lb_valid = lv; lb_in = lb;
    config_en = cfg; config_addr = ca; config_data = cd;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic set_width(input logic [15:0] w);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 32'h0, {16'h0, w});
  endtask

  // Pixel at (line, col) = base + line*width + col + 1; line buffer supplies it minus width.
  // abort_kind: 1 = flush, 2 = config write, both with a live pixel at index stop_at.
  task automatic run_stream(input int width, input int nlines, input bit gaps,
                            input int stop_at, input int abort_kind, input int freeze_at,
                            input logic [15:0] base);
    for (int ln = 0; ln < nlines; ln++) begin
      for (int c = 0; c < width; c++) begin
        int idx;
        logic [15:0] v, lbv;
        logic lv;
        exp_t e;
        idx = ln * width + c;
        v   = base + 16'(idx) + 16'd1;
        lbv = v - 16'(width);
        lv  = (ln >= 1);
        if (idx == stop_at) begin
          if (abort_kind == 1) drive(1'b1, 1'b1, 1'b1, v, lv, lbv, 1'b0, 32'h0, 32'h0);
          else drive(1'b1, 1'b0, 1'b1, v, lv, lbv, 1'b1, 32'h0, 32'(width));
          return;
        end
        if (idx == freeze_at) begin
          repeat (5) drive(1'b0, 1'b1, 1'b1, 16'($urandom), 1'b1, 16'($urandom),
                           1'b1, 32'h0, 32'd3);
        end
        if (gaps) begin
          while ($urandom_range(1, 0) == 0) idle();
        end
        if (lv && c >= 2) begin
          e.win = {v - 16'd2 - 16'(width), v - 16'd1 - 16'(width), v - 16'(width),
                   v - 16'd2, v - 16'd1, v, 16'(c)};
          e.tag = ecyc + 1;
          sb.push_back(e);
        end
        drive(1'b1, 1'b0, 1'b1, v, lv, lv ? lbv : 16'($urandom), 1'b0, 32'h0, 32'h0);
      end
    end
  endtask

  initial begin
    int w0;
    tbl[0] = '{1'b1, 32'h0000_0000, 32'd1,         16'd3};
    tbl[1] = '{1'b1, 32'h0000_0000, 32'd1000,      16'd64};
    tbl[2] = '{1'b1, 32'h0000_0004, 32'd5,         16'd64};
    tbl[3] = '{1'b1, 32'h0000_0300, 32'd10,        16'd10};
    tbl[4] = '{1'b1, 32'h0000_0000, 32'd0,         16'd3};
    tbl[5] = '{1'b1, 32'h0000_0000, 32'd64,        16'd64};
    tbl[6] = '{1'b1, 32'h0000_0000, 32'd65,        16'd64};
    tbl[7] = '{1'b1, 32'h0000_0000, 32'hABCD_0005, 16'd5};
    tbl[8] = '{1'b1, 32'h0000_0000, 32'd2,         16'd3};
    tbl[9] = '{1'b0, 32'h0000_0000, 32'd10,        16'd3};

    reset_n = 1'b0;
    repeat (3) begin
      drive(1'b1, 1'b0, 1'b1, 16'h55, 1'b1, 16'h33, 1'b0, 32'h0, 32'h0);
      check("reset_win_valid", 128'(win_valid), 128'd0);
      check("reset_read_data", 128'(read_data), 128'd64);
      check("reset_err", 128'(err_sticky), 128'd0);
      check("reset_window", 128'({win_top0, win_top1, win_top2, win_bot0, win_bot1,
                                  win_bot2, win_col}), 128'd0);
    end
    clk_en = 1'b1; flush = 1'b0; cur_valid = 1'b0; lb_valid = 1'b0; config_en = 1'b0;
    #2 reset_n = 1'b1;
    idle();

    // Basic stream, width 8: first window at pixel 11 = top {1,2,3}, bot {9,10,11}
    set_width(16'd8);
    w0 = n_win;
    run_stream(8, 3, 1'b0, -1, 0, -1, 16'd0);
    idle();
    check("basic_windows_per_line", 128'(n_win - w0), 128'd12);
    check("basic_err", 128'(err_sticky), 128'd0);

    // Freeze for 5 cycles right after an emitting accept
    set_width(16'd8);
    w0 = n_win;
    run_stream(8, 3, 1'b0, -1, 0, 20, 16'd500);
    idle();
    check("freeze_windows", 128'(n_win - w0), 128'd12);
    check("freeze_width_kept", 128'(read_data), 128'd8);
    check("freeze_err", 128'(err_sticky), 128'd0);

    // Random gaps, width 15
    set_width(16'd15);
    w0 = n_win;
    run_stream(15, 4, 1'b1, -1, 0, -1, 16'd1000);
    idle();
    check("gaps_windows", 128'(n_win - w0), 128'd39);
    check("gaps_err", 128'(err_sticky), 128'd0);

    // Flush mid-line at c=5, then a fresh stream must restart at column 0
    set_width(16'd8);
    run_stream(8, 3, 1'b0, 13, 1, -1, 16'd2000);
    check("flush_err", 128'(err_sticky), 128'd0);
    w0 = n_win;
    run_stream(8, 2, 1'b0, -1, 0, -1, 16'd3000);
    idle();
    check("after_flush_windows", 128'(n_win - w0), 128'd6);
    check("after_flush_err", 128'(err_sticky), 128'd0);

    // Config clamp / decode vectors
    foreach (tbl[i]) begin
      drive(tbl[i].en, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, tbl[i].addr, tbl[i].data);
      check($sformatf("cfg_vec%0d", i), 128'(read_data), 128'(tbl[i].exp));
    end

    // Config write during an accept drops the pixel and restarts the line
    set_width(16'd8);
    run_stream(8, 2, 1'b0, 12, 2, -1, 16'd4000);
    w0 = n_win;
    run_stream(8, 2, 1'b0, -1, 0, -1, 16'd5000);
    idle();
    check("after_cfg_windows", 128'(n_win - w0), 128'd6);
    check("after_cfg_err", 128'(err_sticky), 128'd0);

    // Protocol errors: lb_valid without cur_valid, then lb_valid drop while primed
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h7, 1'b0, 32'h0, 32'h0);
    check("err_lb_only", 128'(err_sticky), 128'd1);
    idle();
    idle();
    check("err_held", 128'(err_sticky), 128'd1);
    drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 32'h0, 32'h0);
    check("err_flush_clear", 128'(err_sticky), 128'd0);
    run_stream(8, 2, 1'b0, -1, 0, -1, 16'd6000);
    check("err_clean_stream", 128'(err_sticky), 128'd0);
    drive(1'b1, 1'b0, 1'b1, 16'h99, 1'b0, 16'h0, 1'b0, 32'h0, 32'h0);
    check("err_lb_drop", 128'(err_sticky), 128'd1);
    drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 32'h0, 32'h0);
    check("err_drop_clear", 128'(err_sticky), 128'd0);
    idle();
    idle();

    check("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
